// File: rtl/nf_uart_receiver.sv
// 8N1 UART receive datapath: synchronises uart_rx, samples each bit at mid-bit using a
// per-frame latched clocks-per-bit divisor, and holds the last good byte behind a valid/ack handshake.
module nf_uart_receiver #(
    parameter int COMP_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COMP_W-1:0] comp,
    input  logic              rec_en,
    input  logic              uart_rx,
    input  logic              rx_ack,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              frm_err,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    rxs;
    logic [COMP_W-1:0]       cnt;
    logic [COMP_W-1:0]       comp_q;
    logic [COMP_W-1:0]       half_cnt;
    logic [COMP_W-1:0]       last_cnt;
    logic [2:0]              bit_idx;
    logic [7:0]              shift_q;

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign half_cnt = comp_q >> 1;
    assign last_cnt = comp_q - COMP_W'(1);
    assign busy     = (state != IDLE);

    // Idle-high synchroniser so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            comp_q   <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            frm_err  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            frm_err <= 1'b0;

            // Consumption; a good frame completing this cycle overrides below
            if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            if (!rec_en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            comp_q <= comp;
                            cnt    <= '0;
                            state  <= START;
                        end
                    end
                    START: begin
                        if (cnt == half_cnt) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= rxs ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + COMP_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt == last_cnt) begin
                            cnt     <= '0;
                            shift_q <= {rxs, shift_q[7:1]};
                            bit_idx <= bit_idx + 3'(1);
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end
                        end else begin
                            cnt <= cnt + COMP_W'(1);
                        end
                    end
                    STOP: begin
                        if (cnt == last_cnt) begin
                            cnt <= '0;
                            if (rxs) begin
                                rx_data  <= shift_q;
                                rx_valid <= 1'b1;
                                if (rx_ack) begin
                                    overrun <= 1'b0;
                                end else if (rx_valid) begin
                                    overrun <= 1'b1;
                                end
                                state <= IDLE;
                            end else begin
                                frm_err <= 1'b1;
                                state   <= BREAK;
                            end
                        end else begin
                            cnt <= cnt + COMP_W'(1);
                        end
                    end
                    BREAK: begin
                        // Held-low line must return high before a new start is accepted
                        if (rxs) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nf_uart_receiver.sv
// Directed and randomised 8N1 frames against a frame-level holding-register model.
module tb_nf_uart_receiver;

    localparam int COMP_W = 16;
    localparam int SYNC   = 2;
    localparam int LAT    = 2 + SYNC;

    logic              clk = 1'b0;
    logic              reset;
    logic [COMP_W-1:0] comp;
    logic              rec_en;
    logic              uart_rx;
    logic              rx_ack;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              frm_err;
    logic              overrun;
    logic              busy;

    always #5 clk = ~clk;

    nf_uart_receiver #(.COMP_W(COMP_W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .comp(comp), .rec_en(rec_en), .uart_rx(uart_rx),
        .rx_ack(rx_ack), .rx_data(rx_data), .rx_valid(rx_valid), .frm_err(frm_err),
        .overrun(overrun), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    int n, rise_n, ferr_cnt, busy_cnt, last_fc;
    int ack_at = -1, en_off_at = -1, rst_at = -1, comp_chg_at = -1;
    logic [COMP_W-1:0] comp_next;
    logic prev_valid, was_valid, ack_seen;

    logic       m_valid, m_ovr;
    logic [7:0] m_data;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        n++;
        if (n == rst_at + 1) begin
            check("rst_mid_data", 32'(rx_data), 0);
            check("rst_mid_valid", 32'(rx_valid), 0);
            check("rst_mid_ferr", 32'(frm_err), 0);
            check("rst_mid_ovr", 32'(overrun), 0);
            check("rst_mid_busy", 32'(busy), 0);
            reset = 1'b0;
        end
        if (rx_ack) rx_ack = 1'b0;
        if (n == ack_at) begin
            rx_ack   = 1'b1;
            ack_seen = 1'b1;
        end
        if (n == en_off_at) rec_en = 1'b0;
        if (n == comp_chg_at) comp = comp_next;
        if (n == rst_at) reset = 1'b1;
        if (rx_valid === 1'b1 && prev_valid !== 1'b1 && rise_n < 0) rise_n = n;
        prev_valid = rx_valid;
        if (frm_err) ferr_cnt++;
        if (busy) busy_cnt++;
    endtask

    task automatic drive(logic v, int cyc);
        uart_rx = v;
        repeat (cyc) tick();
    endtask

    task automatic begin_frame();
        n = 0; rise_n = -1; ferr_cnt = 0; busy_cnt = 0;
        prev_valid = rx_valid;
        was_valid  = rx_valid;
        ack_seen   = 1'b0;
    endtask

    // Line starts changing at a negedge; a bad stop bit is held low for tail extra cycles
    task automatic send(logic [7:0] d, logic stop_ok, int tail);
        last_fc = int'(comp);
        drive(1'b0, last_fc);
        for (int i = 0; i < 8; i++) drive(d[i], last_fc);
        drive(stop_ok, last_fc);
        if (!stop_ok) begin
            drive(1'b0, tail);
            check("break_hold_busy", 32'(busy), 1);
        end
        drive(1'b1, 8);
    endtask

    task automatic finish_frame(string tag, logic [7:0] d, bit good, bit bad_stop);
        if (good) begin
            if (ack_seen) begin
                m_valid = 1'b1; m_data = d; m_ovr = 1'b0;
            end else begin
                m_ovr = m_ovr | m_valid; m_valid = 1'b1; m_data = d;
            end
        end else if (ack_seen && m_valid) begin
            m_valid = 1'b0; m_ovr = 1'b0;
        end
        check({tag, "_data"}, 32'(rx_data), 32'(m_data));
        check({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ferr"}, 32'(ferr_cnt), bad_stop ? 1 : 0);
        check({tag, "_rise"}, 32'(rise_n),
              (good && !was_valid) ? 32'(LAT + last_fc / 2 + 9 * last_fc) : 32'hFFFF_FFFF);
        ack_at = -1; en_off_at = -1; rst_at = -1; comp_chg_at = -1;
    endtask

    task automatic ack_pulse(string tag);
        rx_ack = 1'b1;
        tick();
        if (m_valid) begin
            m_valid = 1'b0; m_ovr = 1'b0;
        end
        check({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    initial begin
        logic [7:0] d;
        bit good;

        reset = 1'b1; comp = 16'd434; rec_en = 1'b1; uart_rx = 1'b1; rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data", 32'(rx_data), 0);
        check("reset_valid", 32'(rx_valid), 0);
        check("reset_ferr", 32'(frm_err), 0);
        check("reset_ovr", 32'(overrun), 0);
        check("reset_busy", 32'(busy), 0);
        reset = 1'b0;
        m_valid = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
        repeat (4) tick();

        // 1: basic frame at 434 clocks per bit
        begin_frame(); send(8'h48, 1'b1, 0); finish_frame("t1", 8'h48, 1, 0);
        ack_pulse("t1_ack");

        // 2: short glitch is rejected at the mid-start sample
        begin_frame(); drive(1'b0, 100); drive(1'b1, 400);
        check("t2_busy_bound", 32'(busy_cnt > 0 && busy_cnt <= 218), 1);
        finish_frame("t2", 8'h00, 0, 0);

        comp = 16'd20;
        // 3: framing error, held-low line, then recovery
        begin_frame(); send(8'h55, 1'b0, 1000); finish_frame("t3", 8'h55, 0, 1);
        begin_frame(); send(8'h21, 1'b1, 0); finish_frame("t3b", 8'h21, 1, 0);
        ack_pulse("t3_ack");

        // 4: overrun then single ack
        begin_frame(); send(8'h41, 1'b1, 0); finish_frame("t4a", 8'h41, 1, 0);
        begin_frame(); send(8'h42, 1'b1, 0); finish_frame("t4b", 8'h42, 1, 0);
        ack_pulse("t4_ack");

        // 5: ack coincides with the good-frame load
        begin_frame(); send(8'h10, 1'b1, 0); finish_frame("t5a", 8'h10, 1, 0);
        begin_frame(); ack_at = LAT - 1 + int'(comp) / 2 + 9 * int'(comp);
        send(8'h11, 1'b1, 0); finish_frame("t5b", 8'h11, 1, 0);
        ack_pulse("t5_ack");

        // 6a: rec_en dropped during data bit 4
        begin_frame(); en_off_at = 5 * int'(comp) + int'(comp) / 2;
        send(8'h7E, 1'b1, 0); rec_en = 1'b1; finish_frame("t6a", 8'h7E, 0, 0);
        begin_frame(); send(8'h33, 1'b1, 0); finish_frame("t6a2", 8'h33, 1, 0);

        // 6b: reset mid-frame with a byte still held
        begin_frame(); rst_at = 3 * int'(comp);
        send(8'hFF, 1'b1, 0);
        m_valid = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
        finish_frame("t6b", 8'hFF, 0, 0);

        // Randomised frames, divisors, acks and mid-frame divisor changes
        for (int k = 0; k < 10; k++) begin
            if (m_valid && $urandom_range(0, 2) == 0) ack_pulse("rnd_ack");
            comp_next = COMP_W'(12 + $urandom_range(0, 30));
            d = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            begin_frame();
            if ($urandom_range(0, 1) == 1) comp_chg_at = 4 * int'(comp);
            else comp = comp_next;
            if (good && m_valid && $urandom_range(0, 1) == 1)
                ack_at = LAT - 1 + int'(comp) / 2 + 9 * int'(comp);
            send(d, good, $urandom_range(1, 50));
            finish_frame("rnd", d, good, !good);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
